ascon_sbox_lut_loader: RTL and testbench
========================================

// Module: ascon_sbox_lut_loader
// PURPOSE
//  Boot-time sequencer that programs the 32-entry, 5-bit Ascon S-box LUT register file over the register bus.
//  Sits between the register-bus fabric and the LUT register file, acting as a bus master.
//  Writes the fixed Ascon S-box table row by row, with optional readback verification.
//  Asserts lut_valid_o so the permutation datapath may use the LUT.
// PARAMETERS
//  BASE_ADDR       32'h0  byte address of LUT row 0; row r at BASE_ADDR + 4*r (r = 0..7)
//  TIMEOUT_CYCLES  256    max cycles a beat may wait for reg_ready_i; 0 = no timeout
// PORTS
//  clk_i        in   1   clock
//  rst_i        in   1   synchronous, active-high reset
//  start_i      in   1   start programming sequence (sampled in IDLE/DONE/ERR only)
//  busy_o       out  1   sequence in progress
//  done_o       out  1   one-cycle pulse on successful completion
//  error_o      out  1   sticky fault flag, cleared by start_i or rst_i
//  lut_valid_o  out  1   LUT contents valid for datapath use
//  reg_valid_o  out  1   bus request valid
//  reg_write_o  out  1   1 = write, 0 = read
//  reg_addr_o   out  32  bus byte address
//  reg_wdata_o  out  32  row data: entry_k in bits [8k+4:8k], other bits 0
//  reg_wstrb_o  out  4   4'hF on writes, 4'h0 on reads
//  reg_ready_i  in   1   bus response ready; beat completes when valid & ready
//  reg_rdata_i  in   32  read data
//  reg_error_i  in   1   bus error, qualified by the completing beat
// BEHAVIOUR
//  Reset: all outputs 0; FSM = IDLE; row counter = 0; timeout counter = 0.
//  Table: S[0..31] = 04 0B 1F 14 1A 15 09 02 1B 05 08 12 1D 03 06 1C
//                    1E 13 07 0E 00 0D 11 18 10 0C 01 19 16 0A 0F 17 (hex)
//  Row r packs entry_k = S[4r+k]. Example: row 0 = 32'h141F0B04.
//  FSM states: IDLE, WR, RD, DONE, ERR.
//   IDLE/DONE/ERR + start_i -> WR, row = 0.
//     Entry clears error_o and lut_valid_o on the next edge.
//   WR: reg_valid_o=1, reg_write_o=1, addr/wdata = row.
//     On completion, row++; after row 7, go to RD (verify) or DONE.
//   RD: reg_valid_o=1, reg_write_o=0. Compare reg_rdata_i under mask 32'h1F1F1F1F against the expected row.
//     After row 7, go to DONE.
//   DONE: done_o=1 for exactly one cycle; lut_valid_o=1 (held until the next start_i or rst_i).
//     FSM then returns to IDLE.
//   ERR: error_o=1, lut_valid_o=0, reg_valid_o=0. Exit only on start_i or rst_i.
//  busy_o=1 in WR and RD.
//  Handshake: address, data, write and strobe are stable while reg_valid_o=1 and reg_ready_i=0.
//  reg_valid_o is never withdrawn before completion, except on rst_i, timeout or ERR.
//  Errors (any of the following -> ERR on the next edge; row counter frozen):
//   - reg_error_i on a completing beat;
//   - read mismatch;
//   - timeout counter reaching TIMEOUT_CYCLES.
//  Timeout counter: clears on each completed beat; counts cycles with valid & !ready.
//  start_i while busy_o=1 is ignored.
//  Latency with reg_ready_i tied high: start_i at edge k.
//   - Beats occupy cycles k+1 .. k+8 (no verify) or k+1 .. k+16 (verify).
//   - done_o is high in the following cycle.
//  rst_i mid-sequence: next edge returns every output to its reset value.
//    In-flight beat is abandoned.
// CONFIGURATION
//  SBOX_VERIFY_EN defined: RD readback phase is compiled in, per BEHAVIOUR.
//  Undefined: RD state and compare logic are absent.
//    WR row 7 completion -> DONE; reg_write_o is constantly 1.
// TESTING
//  1. rst_i, ready=1, pulse start_i:
//     8 writes with addr BASE+0 .. BASE+0x1C, row0 32'h141F0B04, row7 32'h170F0A16.
//     done_o pulses 1 cycle later; lut_valid_o=1.
//  2. Ready stalled 5 cycles on row 3: addr and wdata held constant while stalled.
//     Total time = nominal + 5 cycles; no beat duplicated or skipped.
//  3. reg_error_i=1 on row 2 completion: error_o=1, lut_valid_o=0, no further beats.
//     A new start_i restarts from row 0 and clears error_o.
//  4. TIMEOUT_CYCLES=4, ready held low: ERR entered after 4 stall cycles.
//  5. SBOX_VERIFY_EN, rdata row 5 returns 32'h00000000: ERR.
//     Upper bits of rdata set (e.g. 32'hE0E0E0E0 | expected): pass.
//  6. rst_i asserted mid-WR (row 4): next cycle all outputs 0.
//     A subsequent start_i reprograms from row 0; start_i pulsed during WR is ignored.

Source files
------------

// File: rtl/ascon_sbox_lut_loader.sv
// Boot-time bus master that writes the 32-entry Ascon S-box LUT as eight packed rows.
// Define SBOX_VERIFY_EN to compile in the masked readback (RD) verification phase.
module ascon_sbox_lut_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic        lut_valid_o,
    output logic        reg_valid_o,
    output logic        reg_write_o,
    output logic [31:0] reg_addr_o,
    output logic [31:0] reg_wdata_o,
    output logic [3:0]  reg_wstrb_o,
    input  logic        reg_ready_i,
    input  logic [31:0] reg_rdata_i,
    input  logic        reg_error_i
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    // Row r holds S[4r+k] in bits [8k+4:8k]; the unused bits of each byte stay 0.
    function automatic logic [31:0] row_data(input logic [2:0] r);
        case (r)
            3'd0:    row_data = 32'h141F0B04;
            3'd1:    row_data = 32'h0209151A;
            3'd2:    row_data = 32'h1208051B;
            3'd3:    row_data = 32'h1C06031D;
            3'd4:    row_data = 32'h0E07131E;
            3'd5:    row_data = 32'h18110D00;
            3'd6:    row_data = 32'h19010C10;
            default: row_data = 32'h170F0A16;
        endcase
    endfunction

    logic [2:0]  state_q, state_d;
    logic [2:0]  row_q, row_d;
    logic [31:0] to_q, to_d;
    logic        lut_q, lut_d;

    logic beat_done;
    logic rd_mismatch;
    logic last_wr_next;

    assign busy_o    = (state_q == S_WR) || (state_q == S_RD);
    assign beat_done = busy_o && reg_ready_i;

`ifdef SBOX_VERIFY_EN
    assign rd_mismatch  = (state_q == S_RD) &&
                          ((reg_rdata_i & 32'h1F1F1F1F) != row_data(row_q));
    assign reg_write_o  = (state_q == S_WR);
    assign last_wr_next = 1'b1;
`else
    logic unused_rdata;
    assign unused_rdata = ^reg_rdata_i;
    assign rd_mismatch  = 1'b0;
    assign reg_write_o  = 1'b1;
    assign last_wr_next = 1'b0;
`endif

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        to_d    = to_q;
        lut_d   = lut_q;
        case (state_q)
            S_WR, S_RD: begin
                if (beat_done) begin
                    to_d = 32'd0;
                    if (reg_error_i || rd_mismatch) begin
                        state_d = S_ERR;
                        lut_d   = 1'b0;
                    end else begin
                        row_d = row_q + 3'd1;
                        if (row_q == 3'd7) begin
                            if (state_q == S_WR && last_wr_next) begin
                                state_d = S_RD;
                            end else begin
                                state_d = S_DONE;
                                lut_d   = 1'b1;
                            end
                        end
                    end
                end else if (TIMEOUT_CYCLES != 0 && to_q + 32'd1 == TIMEOUT_CYCLES) begin
                    state_d = S_ERR;
                    lut_d   = 1'b0;
                end else begin
                    to_d = to_q + 32'd1;
                end
            end
            default: begin
                // IDLE, DONE and ERR all accept a fresh start; DONE otherwise falls back to IDLE.
                if (start_i) begin
                    state_d = S_WR;
                    row_d   = 3'd0;
                    to_d    = 32'd0;
                    lut_d   = 1'b0;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            row_q   <= 3'd0;
            to_q    <= 32'd0;
            lut_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            to_q    <= to_d;
            lut_q   <= lut_d;
        end
    end

    assign done_o      = (state_q == S_DONE);
    assign error_o     = (state_q == S_ERR);
    assign lut_valid_o = lut_q;
    assign reg_valid_o = busy_o;
    assign reg_addr_o  = busy_o ? (BASE_ADDR + {27'd0, row_q, 2'b00}) : 32'd0;
    assign reg_wdata_o = (state_q == S_WR) ? row_data(row_q) : 32'd0;
    assign reg_wstrb_o = (state_q == S_WR) ? 4'hF : 4'h0;

endmodule

// File: tb/tb_ascon_sbox_lut_loader.sv
// Directed bench for ascon_sbox_lut_loader; a second instance uses a short timeout.
// Build with SBOX_VERIFY_EN defined to also exercise the readback phase.
module tb_ascon_sbox_lut_loader;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        reg_ready_i = 1'b1;
    logic [31:0] reg_rdata_i = 32'd0;
    logic        reg_error_i = 1'b0;
    logic        busy_o, done_o, error_o, lut_valid_o, reg_valid_o, reg_write_o;
    logic [31:0] reg_addr_o, reg_wdata_o;
    logic [3:0]  reg_wstrb_o;

    logic        start_t = 1'b0;
    logic        ready_t = 1'b0;
    logic        busy_t, done_t, error_t, lut_t, valid_t, write_t;
    logic [31:0] addr_t, wdata_t;
    logic [3:0]  wstrb_t;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_row [8];

    always #5 clk_i = ~clk_i;

    ascon_sbox_lut_loader dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .lut_valid_o(lut_valid_o),
        .reg_valid_o(reg_valid_o), .reg_write_o(reg_write_o), .reg_addr_o(reg_addr_o),
        .reg_wdata_o(reg_wdata_o), .reg_wstrb_o(reg_wstrb_o), .reg_ready_i(reg_ready_i),
        .reg_rdata_i(reg_rdata_i), .reg_error_i(reg_error_i)
    );

    ascon_sbox_lut_loader #(.BASE_ADDR(32'h0), .TIMEOUT_CYCLES(4)) dut_to (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_t),
        .busy_o(busy_t), .done_o(done_t), .error_o(error_t), .lut_valid_o(lut_t),
        .reg_valid_o(valid_t), .reg_write_o(write_t), .reg_addr_o(addr_t),
        .reg_wdata_o(wdata_t), .reg_wstrb_o(wstrb_t), .reg_ready_i(ready_t),
        .reg_rdata_i(32'd0), .reg_error_i(1'b0)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " busy"},  {31'd0, busy_o},      32'd0);
        chk({tag, " done"},  {31'd0, done_o},      32'd0);
        chk({tag, " error"}, {31'd0, error_o},     32'd0);
        chk({tag, " lut"},   {31'd0, lut_valid_o}, 32'd0);
        chk({tag, " valid"}, {31'd0, reg_valid_o}, 32'd0);
        chk({tag, " addr"},  reg_addr_o,           32'd0);
        chk({tag, " wdata"}, reg_wdata_o,          32'd0);
        chk({tag, " wstrb"}, {28'd0, reg_wstrb_o}, 32'd0);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Eight write beats; optionally stall ready for stall_n cycles on stall_row.
    task automatic write_beats(input int stall_row, input int stall_n);
        for (int r = 0; r < 8; r++) begin
            if (r == stall_row) begin
                reg_ready_i = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    chk($sformatf("stall%0d valid", s), {31'd0, reg_valid_o}, 32'd1);
                    chk($sformatf("stall%0d addr", s),  reg_addr_o, 32'(4 * r));
                    chk($sformatf("stall%0d wdata", s), reg_wdata_o, exp_row[r]);
                    tick();
                end
                reg_ready_i = 1'b1;
            end
            chk($sformatf("wr%0d valid", r), {31'd0, reg_valid_o}, 32'd1);
            chk($sformatf("wr%0d write", r), {31'd0, reg_write_o}, 32'd1);
            chk($sformatf("wr%0d addr", r),  reg_addr_o, 32'(4 * r));
            chk($sformatf("wr%0d wdata", r), reg_wdata_o, exp_row[r]);
            chk($sformatf("wr%0d wstrb", r), {28'd0, reg_wstrb_o}, 32'hF);
            tick();
        end
    endtask

`ifdef SBOX_VERIFY_EN
    // Eight read beats returning expected data with junk upper bits; bad_row returns zero.
    task automatic read_beats(input int bad_row);
        for (int r = 0; r < 8; r++) begin
            chk($sformatf("rd%0d valid", r), {31'd0, reg_valid_o}, 32'd1);
            chk($sformatf("rd%0d write", r), {31'd0, reg_write_o}, 32'd0);
            chk($sformatf("rd%0d addr", r),  reg_addr_o, 32'(4 * r));
            reg_rdata_i = (r == bad_row) ? 32'd0 : (exp_row[r] | 32'hE0E0E0E0);
            tick();
            if (r == bad_row) begin
                chk("rd mismatch error", {31'd0, error_o}, 32'd1);
                chk("rd mismatch valid", {31'd0, reg_valid_o}, 32'd0);
                return;
            end
        end
    endtask
`endif

    task automatic finish_and_check_done(input string tag);
`ifdef SBOX_VERIFY_EN
        read_beats(-1);
`endif
        chk({tag, " done pulse"}, {31'd0, done_o},      32'd1);
        chk({tag, " lut set"},    {31'd0, lut_valid_o}, 32'd1);
        chk({tag, " busy low"},   {31'd0, busy_o},      32'd0);
        tick();
        chk({tag, " done once"},  {31'd0, done_o},      32'd0);
        chk({tag, " lut held"},   {31'd0, lut_valid_o}, 32'd1);
    endtask

    initial begin
        exp_row[0] = 32'h141F0B04; exp_row[1] = 32'h0209151A;
        exp_row[2] = 32'h1208051B; exp_row[3] = 32'h1C06031D;
        exp_row[4] = 32'h0E07131E; exp_row[5] = 32'h18110D00;
        exp_row[6] = 32'h19010C10; exp_row[7] = 32'h170F0A16;

        // Reset state
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        check_idle_outputs("reset");

        // Nominal sequence, ready tied high
        pulse_start();
        write_beats(-1, 0);
        finish_and_check_done("nominal");

        // Five-cycle stall on row 3; done lands exactly five cycles later
        pulse_start();
        write_beats(3, 5);
        finish_and_check_done("stall");

        // Bus error on row 2 completion
        pulse_start();
        chk("restart clears lut", {31'd0, lut_valid_o}, 32'd0);
        tick();
        tick();
        chk("err row2 addr", reg_addr_o, 32'h8);
        reg_error_i = 1'b1;
        tick();
        reg_error_i = 1'b0;
        chk("buserr error", {31'd0, error_o},     32'd1);
        chk("buserr lut",   {31'd0, lut_valid_o}, 32'd0);
        chk("buserr valid", {31'd0, reg_valid_o}, 32'd0);
        tick();
        tick();
        chk("buserr sticky", {31'd0, error_o},     32'd1);
        chk("buserr quiet",  {31'd0, reg_valid_o}, 32'd0);
        pulse_start();
        chk("restart clears error", {31'd0, error_o}, 32'd0);
        write_beats(-1, 0);
        finish_and_check_done("after err");

        // Timeout instance: ready held low, ERR after four stall cycles
        start_t = 1'b1;
        tick();
        start_t = 1'b0;
        chk("to valid", {31'd0, valid_t}, 32'd1);
        tick();
        tick();
        tick();
        chk("to not yet", {31'd0, error_t}, 32'd0);
        chk("to still valid", {31'd0, valid_t}, 32'd1);
        chk("to addr held", addr_t, 32'd0);
        tick();
        chk("to error", {31'd0, error_t}, 32'd1);
        chk("to valid drop", {31'd0, valid_t}, 32'd0);

`ifdef SBOX_VERIFY_EN
        // Readback mismatch on row 5
        pulse_start();
        write_beats(-1, 0);
        read_beats(5);
        chk("mismatch lut", {31'd0, lut_valid_o}, 32'd0);
`endif

        // start ignored while busy, then reset mid-write on row 4
        pulse_start();
        tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("start ignored", reg_addr_o, 32'h8);
        tick();
        tick();
        chk("row4 reached", reg_addr_o, 32'h10);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check_idle_outputs("midreset");
        pulse_start();
        write_beats(-1, 0);
        finish_and_check_done("after reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
